// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: flag register with same-cycle bypass, condition
// evaluation, target computation, registered redirect, flush sequencing and stats.
module branch_resolve_unit #(
  parameter int PC_W         = 16,
  parameter int OFF_W        = 9,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flags_we,
  input  logic [2:0]       flags_in,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc_plus1,
  input  logic [OFF_W-1:0] br_offset,
  output logic [2:0]       flags_out,
  output logic             redirect,
  output logic [PC_W-1:0]  target_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t             state_q, state_d;
  logic [2:0]         fcnt_q, fcnt_d;
  logic [2:0]         flags_q, flags_d;
  logic               redirect_q, redirect_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   tk_cnt_q, tk_cnt_d;

  logic [2:0]         eff_flags;
  logic               flag_v, flag_z, flag_n;
  logic               cond_true;
  logic [PC_W-1:0]    offset_sext;
  logic [PC_W-1:0]    target_calc;

  // The flag producer writes in the same cycle the branch evaluates, so bypass it.
  assign eff_flags = flags_we ? flags_in : flags_q;
  assign flag_v    = eff_flags[2];
  assign flag_z    = eff_flags[1];
  assign flag_n    = eff_flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = !flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z && !flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z || !flag_n;
      3'b101:  cond_true = flag_z || flag_n;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign offset_sext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign target_calc = br_pc_plus1 + offset_sext;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    flags_d    = flags_q;
    redirect_d = redirect_q;
    target_d   = target_q;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;

    if (!stall) begin
      if (flags_we) begin
        flags_d = flags_in;
      end
      case (state_q)
        S_IDLE: begin
          if (br_valid) begin
            br_cnt_d = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + CNT_W'(1);
            if (cond_true) begin
              tk_cnt_d   = (tk_cnt_q == '1) ? tk_cnt_q : tk_cnt_q + CNT_W'(1);
              redirect_d = 1'b1;
              target_d   = target_calc;
              fcnt_d     = FLUSH_LOAD;
              state_d    = S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Branches seen here are wrong-path and are dropped.
          redirect_d = 1'b0;
          fcnt_d     = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          fcnt_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fcnt_q     <= 3'd0;
      flags_q    <= 3'b000;
      redirect_q <= 1'b0;
      target_q   <= '0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      flags_q    <= flags_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      br_cnt_q   <= br_cnt_d;
      tk_cnt_q   <= tk_cnt_d;
    end
  end

  assign flags_out   = flags_q;
  assign redirect    = redirect_q;
  assign target_pc   = target_q;
  assign flush       = (state_q == S_FLUSH);
  assign busy        = (state_q == S_FLUSH);
  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a cycle-level reference model.
module tb_branch_resolve_unit;
  localparam int PC_W  = 16;
  localparam int OFF_W = 9;
  localparam int FC    = 2;
  // Narrow counters keep the saturation scenario short.
  localparam int CW    = 10;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             flags_we;
  logic [2:0]       flags_in;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic [PC_W-1:0]  br_pc_plus1;
  logic [OFF_W-1:0] br_offset;
  logic [2:0]       flags_out;
  logic             redirect;
  logic [PC_W-1:0]  target_pc;
  logic             flush;
  logic             busy;
  logic [CW-1:0]    br_count;
  logic [CW-1:0]    taken_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flags_we(flags_we), .flags_in(flags_in),
    .br_valid(br_valid), .br_cond(br_cond), .br_pc_plus1(br_pc_plus1), .br_offset(br_offset),
    .flags_out(flags_out), .redirect(redirect), .target_pc(target_pc), .flush(flush),
    .busy(busy), .br_count(br_count), .taken_count(taken_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [2:0]      m_flags;
  int              m_busy_left;
  bit              m_redir;
  logic [PC_W-1:0] m_target;
  int              m_br;
  int              m_tk;

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit v, z, n;
    v = f[2]; z = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 3'b000; m_busy_left = 0; m_redir = 0; m_target = '0; m_br = 0; m_tk = 0;
  endtask

  task automatic model_step();
    logic [2:0] eff;
    int tgt;
    if (stall) return;
    eff = flags_we ? flags_in : m_flags;
    if (flags_we) m_flags = flags_in;
    if (m_busy_left > 0) begin
      m_busy_left--;
      m_redir = 0;
    end else if (br_valid) begin
      if (m_br < CMAX) m_br++;
      if (cond_ok(br_cond, eff)) begin
        if (m_tk < CMAX) m_tk++;
        tgt = int'(br_pc_plus1) + int'($signed(br_offset));
        m_target = PC_W'(tgt);
        m_redir = 1;
        m_busy_left = FC;
      end
    end
  endtask

  task automatic check_outputs();
    chk("flags_out", 32'(flags_out), 32'(m_flags));
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("target_pc", 32'(target_pc), 32'(m_target));
    chk("flush", 32'(flush), 32'(m_busy_left > 0));
    chk("busy", 32'(busy), 32'(m_busy_left > 0));
    chk("br_count", 32'(br_count), 32'(m_br));
    chk("taken_count", 32'(taken_count), 32'(m_tk));
  endtask

  // Drive at a negedge, let one posedge pass, compare at the following negedge.
  task automatic cyc(input logic s, input logic we, input logic [2:0] fi, input logic bv,
                     input logic [2:0] c, input logic [PC_W-1:0] pc, input logic [OFF_W-1:0] off);
    stall = s; flags_we = we; flags_in = fi; br_valid = bv;
    br_cond = c; br_pc_plus1 = pc; br_offset = off;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flags_we = 0; flags_in = 0; br_valid = 0;
    br_cond = 0; br_pc_plus1 = 0; br_offset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Bypass: same-cycle Z=1 makes EQ taken
    cyc(1'b0, 1'b1, 3'b010, 1'b1, 3'b001, 16'h0010, 9'h005);
    chk("bp_redirect", 32'(redirect), 32'd1);
    chk("bp_target", 32'(target_pc), 32'h0015);
    chk("bp_taken", 32'(taken_count), 32'd1);
    chk("bp_flags", 32'(flags_out), 32'b010);
    chk("bp_flush0", 32'(flush), 32'd1);
    idle();
    chk("bp_flush1", 32'(flush), 32'd1);
    chk("bp_redir_drop", 32'(redirect), 32'd0);
    idle();
    chk("bp_flush_done", 32'(flush), 32'd0);

    // Not taken GT with N=1, then LT taken with negative offset
    cyc(1'b0, 1'b1, 3'b001, 1'b0, 3'b000, '0, '0);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b010, 16'h0100, 9'h1FE);
    chk("gt_no_redirect", 32'(redirect), 32'd0);
    chk("gt_br_count", 32'(br_count), 32'd2);
    chk("gt_taken_count", 32'(taken_count), 32'd1);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b011, 16'h0100, 9'h1FE);
    chk("lt_target", 32'(target_pc), 32'h00FE);
    chk("lt_redirect", 32'(redirect), 32'd1);
    idle(); idle();

    // Wrong-path branches during busy are squashed
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'h0200, 9'h000);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'h0300, 9'h000);
    chk("sq_redir_once", 32'(redirect), 32'd0);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'h0400, 9'h000);
    chk("sq_br_count", 32'(br_count), 32'd4);
    chk("sq_taken_count", 32'(taken_count), 32'd3);
    chk("sq_busy_done", 32'(busy), 32'd0);
    chk("sq_target", 32'(target_pc), 32'h0200);

    // Stall during the redirect cycle
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'h0300, 9'h001);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 3'b111, 1'b1, 3'b111, 16'h0500, 9'h000);
      chk("st_redirect_hold", 32'(redirect), 32'd1);
      chk("st_flags_hold", 32'(flags_out), 32'b001);
    end
    idle();
    chk("st_redirect_drop", 32'(redirect), 32'd0);
    chk("st_flush_rem", 32'(flush), 32'd1);
    idle();
    chk("st_flush_done", 32'(flush), 32'd0);
    chk("st_br_count", 32'(br_count), 32'd5);

    // Target wrap-around
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'hFFFE, 9'h004);
    chk("wrap_target", 32'(target_pc), 32'h0002);
    idle(); idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1), 3'($urandom),
          ($urandom_range(0, 2) != 0), 3'($urandom), PC_W'($urandom), OFF_W'($urandom));
    end
    idle(); idle();

    // Async reset mid-flush, between clock edges
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'h1234, 9'h010);
    chk("ar_pre_flush", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flush", 32'(flush), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_redirect", 32'(redirect), 32'd0);
    chk("ar_flags", 32'(flags_out), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 16'h0040, 9'h010);
    chk("ar_first_target", 32'(target_pc), 32'h0050);
    chk("ar_first_count", 32'(br_count), 32'd1);
    idle(); idle();

    // Saturation of both counters
    for (int i = 0; i < CMAX + 8; i++) begin
      cyc(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 16'h0000, 9'h000);
      idle(); idle();
    end
    chk("sat_br", 32'(br_count), 32'(CMAX));
    chk("sat_taken", 32'(taken_count), 32'(CMAX));
    cyc(1'b0, 1'b1, 3'b100, 1'b1, 3'b110, 16'h0000, 9'h000);
    chk("sat_br_hold", 32'(br_count), 32'(CMAX));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural {V,Z,N} flag register written by flag-setting ALU ops.
- In EX, it evaluates branch conditions against those flags, with a same-cycle bypass from the producing instruction.
- It computes the branch target, issues a registered redirect to fetch, and sequences the pipeline flush. Branch and taken statistics counters sit alongside.

Parameters:
- PC_W, 16, PC and target width.
- OFF_W, 9, branch offset width in words; sign-extended to PC_W.
- FLUSH_CYCLES, 2, cycles the younger-stage flush stays asserted after a taken branch (1..7).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline stall; freezes all state in this block
- flags_we  in  1  ALU result this cycle updates flags
- flags_in  in  3  {V,Z,N} from ALU; bit2=V, bit1=Z, bit0=N
- br_valid  in  1  branch instruction present in EX this cycle
- br_cond  in  3  condition code
- br_pc_plus1  in  PC_W  address of the instruction after the branch
- br_offset  in  OFF_W  signed word offset
- flags_out  out  3  architectural flag register {V,Z,N}
- redirect  out  1  one-cycle pulse: fetch loads target_pc
- target_pc  out  PC_W  branch target, valid while redirect=1
- flush  out  1  squash IF/ID and ID/EX contents
- busy  out  1  flush sequence in progress
- br_count  out  CNT_W  branches resolved (saturating)
- taken_count  out  CNT_W  branches taken (saturating)

Behaviour:
- Reset (async, rst_n=0): flags_out=3'b000, redirect=0, target_pc=0, flush=0, busy=0, br_count=0, taken_count=0, flush counter=0.
- Flag register: on a clk edge with stall=0 and flags_we=1, flags_out <= flags_in. Otherwise it holds.
- Effective flags: flags_in when flags_we=1 in the same cycle, otherwise flags_out. This bypass is required because the flag producer sits one stage ahead and writes in the same cycle the branch reaches EX.
- Condition codes, evaluated on the effective flags:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or N=0
  - 101 LTE: Z=1 or N=1
  - 110 OVFL: V=1
  - 111 UNCOND: always taken
- Target: br_pc_plus1 + sign_extend(br_offset), modulo 2^PC_W; wrap-around is allowed and is not an error.
- Branch is accepted when br_valid=1, stall=0 and busy=0. On acceptance:
  - br_count increments, saturating at all-ones.
  - If taken, taken_count increments (saturating), and at the next edge redirect=1 and target_pc=computed target.
  - The flush counter loads FLUSH_CYCLES; flush=1 and busy=1 from that edge.
- Latency: exactly 1 cycle from accepted branch to redirect/flush assertion.
- State machine:
  - IDLE: redirect=0, flush=0, busy=0.
  - IDLE -> FLUSHING on a taken accept.
  - FLUSHING: redirect=1 in the first cycle only. flush=1 and busy=1 for FLUSH_CYCLES cycles while the counter decrements; leaves to IDLE when the counter reaches 0.
  - A not-taken accept stays in IDLE and produces no outputs except br_count.
- While busy=1, br_valid is ignored: the branch is a wrong-path instruction being squashed, so no counting and no redirect. flags_we is still honoured (the flag-writer is older than the branch).
- While stall=1: everything holds — flag register, counters, FSM and flush counter — including redirect if it is currently 1. A stalled redirect cycle therefore extends until stall drops; fetch must see exactly one unstalled redirect cycle.
- target_pc holds its last value when redirect=0.
- Not-taken branches never affect target_pc.
- Reset mid-flush: returns to IDLE immediately; flush and redirect deassert asynchronously.

Test Plan:
- Bypass: flags_we=1 with flags_in=3'b010 (Z=1) in the same cycle as br_valid, cond=001, pc_plus1=16'h0010, offset=9'h005 → next cycle redirect=1, target_pc=16'h0015, flush=1 for 2 cycles, taken_count=1; flags_out=3'b010.
- Not taken plus negative offset: flags_out=3'b001 (N=1), cond=010 GT, offset=9'h1FE → no redirect, br_count +1, taken_count unchanged. Then cond=011 LT → target=pc_plus1−2, redirect pulses once.
- Wrong-path squash: taken UNCOND, then br_valid=1 in each of the next 2 busy cycles → counters grow by exactly 1, exactly one redirect, busy low after 2 cycles.
- Stall: stall=1 in the redirect cycle for 3 cycles → redirect, flush, flags and counters hold; after release, redirect drops next cycle and flush completes its remaining count.
- Saturation and wrap: preload via 65535 taken branches → br_count=taken_count=16'hFFFF, further branches hold. pc_plus1=16'hFFFE, offset=9'h004 → target_pc=16'h0002.
- Async reset: assert rst_n=0 mid-FLUSHING, between edges → flush, busy and redirect go 0 immediately; flags_out=0; first branch after release behaves as from IDLE.
